retire_trace_pipe: RTL and testbench

//  Synthesisable retirement tracer for the RV32 pipeline. It captures each issued instruction's
//  PC, encoding, format class and register indices, and shadows them through NUM_STAGES

---
 rtl/retire_trace_pkg.sv | 32 +++
 rtl/trace_fifo.sv | 48 ++++
 rtl/retire_trace_pipe.sv | 131 +++++++++++++
 tb/tb_retire_trace_pipe.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/retire_trace_pkg.sv
// Shared types for the retirement tracer: instruction class encodings, the
// per-slot shadow record and the trace record emitted at retirement.
package retire_trace_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] CLASS_R = 6'b000001;
    localparam logic [5:0] CLASS_I = 6'b000010;
    localparam logic [5:0] CLASS_S = 6'b000100;
    localparam logic [5:0] CLASS_B = 6'b001000;
    localparam logic [5:0] CLASS_U = 6'b010000;
    localparam logic [5:0] CLASS_J = 6'b100000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [5:0]      cls;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
    } slot_t;

    typedef struct packed {
        slot_t           slot;
        logic [XLEN-1:0] rd_val;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/trace_fifo.sv
// Synchronous valid/ready FIFO with an extra pointer bit for full/empty and a
// push_drop strobe for pushes refused because the FIFO is full and not popping.
module trace_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     push_data,
    input  logic pop_ready,
    output T     data,
    output logic full,
    output logic empty,
    output logic push_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    T            mem [DEPTH];
    logic        pop;
    logic        push_ok;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Handshake: a record leaves when !empty & pop_ready; a pop on full frees room for a push in the same cycle.
    assign pop       = ~empty & pop_ready;
    assign push_ok   = push & (~full | pop);
    assign push_drop = push & full & ~pop;
    assign data      = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/retire_trace_pipe.sv
// Shadows issued instructions through NUM_STAGES slots under stall/flush and,
// at write-back retirement, joins register values into a trace record FIFO.
module retire_trace_pipe
    import retire_trace_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  iss_valid_i,
    input  logic [XLEN-1:0]       iss_pc_i,
    input  logic [31:0]           iss_instr_i,
    input  logic [5:0]            iss_class_i,
    input  logic [4:0]            iss_rd_i,
    input  logic [4:0]            iss_rs1_i,
    input  logic [4:0]            iss_rs2_i,
    input  logic                  stall_i,
    input  logic [NUM_STAGES-1:0] flush_i,
    input  logic                  retire_i,
    input  logic [XLEN-1:0]       wb_rd_val_i,
    input  logic [XLEN-1:0]       wb_rs1_val_i,
    input  logic [XLEN-1:0]       wb_rs2_val_i,
    output logic                  trc_valid_o,
    input  logic                  trc_ready_i,
    output logic [REC_W-1:0]      trc_rec_o,
    output logic [CNT_W-1:0]      retire_cnt_o,
    output logic                  err_overflow_o,
    output logic                  err_orphan_o,
    output logic                  err_lost_o
);

    localparam int W = NUM_STAGES - 1;

    slot_t      slot_q [NUM_STAGES];
    logic       vld_q  [NUM_STAGES];
    slot_t      iss_slot;
    trace_rec_t rec;
    trace_rec_t fifo_data;
    logic       rec_push;
    logic       rec_accept;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push_drop;

    always_comb begin
        iss_slot       = '0;
        iss_slot.pc    = iss_pc_i;
        iss_slot.instr = iss_instr_i;
        iss_slot.cls   = iss_class_i;
        iss_slot.rd    = iss_rd_i;
        iss_slot.rs1   = iss_rs1_i;
        iss_slot.rs2   = iss_rs2_i;
    end

    // A flush kills the entry currently in slot i, so it never lands in slot i+1.
    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_slot
        if (i == 0) begin : g_head
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld_q[0]  <= 1'b0;
                    slot_q[0] <= '0;
                end else if (!stall_i) begin
                    vld_q[0]  <= iss_valid_i;
                    slot_q[0] <= iss_slot;
                end else begin
                    vld_q[0]  <= vld_q[0] & ~flush_i[0];
                end
            end
        end else begin : g_tail
            localparam bit IS_WB = (i == W);
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld_q[i]  <= 1'b0;
                    slot_q[i] <= '0;
                end else if (!stall_i) begin
                    vld_q[i]  <= vld_q[i-1] & ~flush_i[i-1];
                    slot_q[i] <= slot_q[i-1];
                end else begin
                    vld_q[i]  <= vld_q[i] & ~flush_i[i] & ~(IS_WB & retire_i);
                end
            end
        end
    end

    always_comb begin
        rec         = '0;
        rec.slot    = slot_q[W];
        rec.rd_val  = wb_rd_val_i;
        rec.rs1_val = wb_rs1_val_i;
        rec.rs2_val = wb_rs2_val_i;
    end

    assign rec_push    = retire_i & vld_q[W] & ~flush_i[W];
    assign fifo_pop    = trc_valid_o & trc_ready_i;
    assign rec_accept  = rec_push & (~fifo_full | fifo_pop);
    assign trc_valid_o = ~fifo_empty;
    assign trc_rec_o   = fifo_data;

    trace_fifo #(
        .T     (trace_rec_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rec_push),
        .push_data (rec),
        .pop_ready (trc_ready_i),
        .data      (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .push_drop (push_drop)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_cnt_o   <= '0;
            err_overflow_o <= 1'b0;
            err_orphan_o   <= 1'b0;
            err_lost_o     <= 1'b0;
        end else begin
            if (rec_accept) retire_cnt_o <= retire_cnt_o + 1'b1;
            if (push_drop) err_overflow_o <= 1'b1;
            if (retire_i & ~vld_q[W]) err_orphan_o <= 1'b1;
            if (vld_q[W] & ~retire_i & ~stall_i & ~flush_i[W]) err_lost_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_retire_trace_pipe.sv
// Directed and table-driven bench for retire_trace_pipe with an expected-record queue.
module tb_retire_trace_pipe;
    import retire_trace_pkg::*;

    localparam int NS = 4;
    localparam int FD = 8;
    localparam int CW = 32;

    logic             clk_tb = 1'b0;
    logic             rst_n;
    logic             iss_valid_i;
    logic [31:0]      iss_pc_i;
    logic [31:0]      iss_instr_i;
    logic [5:0]       iss_class_i;
    logic [4:0]       iss_rd_i, iss_rs1_i, iss_rs2_i;
    logic             stall_i;
    logic [NS-1:0]    flush_i;
    logic             retire_i;
    logic [31:0]      wb_rd_val_i, wb_rs1_val_i, wb_rs2_val_i;
    logic             trc_valid_o;
    logic             trc_ready_i;
    logic [REC_W-1:0] trc_rec_o;
    logic [CW-1:0]    retire_cnt_o;
    logic             err_overflow_o, err_orphan_o, err_lost_o;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [REC_W-1:0] exp_q[$];
    int               exp_occ = 0;

    typedef struct {
        slot_t       s;
        logic [31:0] rd_val;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] exp_cnt;
    } vec_t;
    vec_t vec [4];

    always #5 clk_tb = ~clk_tb;

    retire_trace_pipe #(.NUM_STAGES(NS), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
        .clk(clk_tb), .reset(rst_n),
        .iss_valid_i(iss_valid_i), .iss_pc_i(iss_pc_i), .iss_instr_i(iss_instr_i),
        .iss_class_i(iss_class_i), .iss_rd_i(iss_rd_i), .iss_rs1_i(iss_rs1_i),
        .iss_rs2_i(iss_rs2_i), .stall_i(stall_i), .flush_i(flush_i), .retire_i(retire_i),
        .wb_rd_val_i(wb_rd_val_i), .wb_rs1_val_i(wb_rs1_val_i), .wb_rs2_val_i(wb_rs2_val_i),
        .trc_valid_o(trc_valid_o), .trc_ready_i(trc_ready_i), .trc_rec_o(trc_rec_o),
        .retire_cnt_o(retire_cnt_o), .err_overflow_o(err_overflow_o),
        .err_orphan_o(err_orphan_o), .err_lost_o(err_lost_o)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_tb);
        #1;
    endtask

    task automatic drive_idle();
        iss_valid_i = 1'b0; iss_pc_i = '0; iss_instr_i = '0; iss_class_i = '0;
        iss_rd_i = '0; iss_rs1_i = '0; iss_rs2_i = '0;
        stall_i = 1'b0; flush_i = '0; retire_i = 1'b0;
        wb_rd_val_i = '0; wb_rs1_val_i = '0; wb_rs2_val_i = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        trc_ready_i = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        exp_occ = 0;
        tick();
    endtask

    function automatic slot_t mk_slot(input logic [31:0] pc);
        slot_t s;
        logic [5:0] one;
        one     = 6'b000001;
        s.pc    = pc;
        s.instr = {pc[11:0], 20'h00033};
        s.cls   = one << (int'(pc[4:2]) % 6);
        s.rd    = pc[6:2];
        s.rs1   = pc[6:2] + 5'd1;
        s.rs2   = pc[6:2] + 5'd2;
        return s;
    endfunction

    task automatic set_iss(input slot_t s);
        iss_valid_i = 1'b1; iss_pc_i = s.pc; iss_instr_i = s.instr; iss_class_i = s.cls;
        iss_rd_i = s.rd; iss_rs1_i = s.rs1; iss_rs2_i = s.rs2;
    endtask

    // Drives a retire for slot s this cycle; models FIFO acceptance and the same-cycle pop.
    task automatic retire_slot(input slot_t s, input logic [31:0] rv, input logic [31:0] v1,
                               input logic [31:0] v2);
        trace_rec_t r;
        logic pop_now;
        retire_i = 1'b1; wb_rd_val_i = rv; wb_rs1_val_i = v1; wb_rs2_val_i = v2;
        r.slot = s; r.rd_val = rv; r.rs1_val = v1; r.rs2_val = v2;
        pop_now = trc_ready_i && (exp_occ > 0);
        if (pop_now) begin
            chk("pop_head", trc_rec_o, exp_q.pop_front());
            exp_occ--;
        end
        if (exp_occ < FD) begin
            exp_q.push_back(r);
            exp_occ++;
        end
    endtask

    task automatic stream(input logic [31:0] base, input int n, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            drive_idle();
            if (c < n) set_iss(mk_slot(base + 32'(4 * c)));
            if (c >= 4 && c - 4 < n)
                retire_slot(mk_slot(base + 32'(4 * (c - 4))), $urandom, $urandom,
                            32'($urandom_range(0, 1000)));
            tick();
        end
        drive_idle();
    endtask

    task automatic drain(input string nm, input int max_cycles);
        trc_ready_i = 1'b1;
        for (int k = 0; k < max_cycles; k++) begin
            if (!trc_valid_o) break;
            if (exp_q.size() == 0) begin
                chk({nm, "_unexpected"}, trc_valid_o, 1'b0);
                break;
            end
            chk(nm, trc_rec_o, exp_q.pop_front());
            tick();
        end
        trc_ready_i = 1'b0;
        chk({nm, "_q_empty"}, exp_q.size(), 0);
        chk({nm, "_valid_low"}, trc_valid_o, 1'b0);
        exp_occ = 0;
    endtask

    initial begin
        trace_rec_t r;
        slot_t sa, sb, sc, sx;

        vec[0] = '{s: '{pc: 32'h100, instr: 32'h002081B3, cls: CLASS_R, rd: 5'd3, rs1: 5'd1, rs2: 5'd2},
                   rd_val: 32'd7, rs1_val: 32'd3, rs2_val: 32'd4, exp_cnt: 32'd1};
        vec[1] = '{s: '{pc: 32'h104, instr: 32'h00812283, cls: CLASS_I, rd: 5'd5, rs1: 5'd2, rs2: 5'd0},
                   rd_val: 32'hDEADBEEF, rs1_val: 32'h1000, rs2_val: 32'h0, exp_cnt: 32'd2};
        vec[2] = '{s: '{pc: 32'h108, instr: 32'h0063A623, cls: CLASS_S, rd: 5'd0, rs1: 5'd7, rs2: 5'd6},
                   rd_val: 32'h0, rs1_val: 32'h2000, rs2_val: 32'hA5A5A5A5, exp_cnt: 32'd3};
        vec[3] = '{s: '{pc: 32'hFFFFFFFC, instr: 32'h000000EF, cls: CLASS_J, rd: 5'd1, rs1: 5'd0, rs2: 5'd0},
                   rd_val: 32'hFFFFFFFF, rs1_val: 32'h0, rs2_val: 32'h0, exp_cnt: 32'd4};

        rst_n = 1'b0;
        drive_idle();
        trc_ready_i = 1'b0;
        do_reset();
        chk("rst_valid", trc_valid_o, 1'b0);
        chk("rst_rec", trc_rec_o, '0);
        chk("rst_cnt", retire_cnt_o, '0);
        chk("rst_errs", {err_overflow_o, err_orphan_o, err_lost_o}, 3'b000);

        // Reset mid-stream: three slots valid, two records queued.
        stream(32'h80, 5, 6);
        chk("mid_setup_valid", trc_valid_o, 1'b1);
        chk("mid_setup_cnt", retire_cnt_o, 32'd2);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", trc_valid_o, 1'b0);
        chk("mid_rst_rec", trc_rec_o, '0);
        chk("mid_rst_cnt", retire_cnt_o, '0);
        chk("mid_rst_errs", {err_overflow_o, err_orphan_o, err_lost_o}, 3'b000);
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        exp_occ = 0;
        for (int k = 0; k < 6; k++) tick();
        chk("mid_post_valid", trc_valid_o, 1'b0);
        chk("mid_post_errs", {err_overflow_o, err_orphan_o, err_lost_o}, 3'b000);

        // Table-driven single-instruction retirements.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_idle();
            set_iss(vec[i].s);
            tick();
            drive_idle();
            for (int k = 0; k < 3; k++) tick();
            chk("tbl_pre_valid", trc_valid_o, 1'b0);
            retire_slot(vec[i].s, vec[i].rd_val, vec[i].rs1_val, vec[i].rs2_val);
            tick();
            drive_idle();
            chk("tbl_valid", trc_valid_o, 1'b1);
            chk("tbl_rec", trc_rec_o, exp_q.pop_front());
            exp_occ--;
            chk("tbl_cnt", retire_cnt_o, vec[i].exp_cnt);
            trc_ready_i = 1'b1;
            tick();
            trc_ready_i = 1'b0;
            chk("tbl_popped", trc_valid_o, 1'b0);
            chk("tbl_errs", {err_overflow_o, err_orphan_o, err_lost_o}, 3'b000);
        end

        // Stall two cycles with the older instruction in slot 2 and a flush of the younger one in slot 1.
        sa = mk_slot(32'h200);
        sb = mk_slot(32'h204);
        sc = mk_slot(32'h208);
        drive_idle(); set_iss(sa); tick();
        drive_idle(); set_iss(sb); tick();
        drive_idle(); tick();
        stall_i = 1'b1; flush_i = 4'b0010; set_iss(sc); tick();
        flush_i = '0; tick();
        drive_idle(); tick();
        retire_slot(sa, 32'h11, 32'h22, 32'h33);
        tick();
        drive_idle();
        chk("stall_cnt", retire_cnt_o, 32'd5);
        drain("stall_rec", 4);
        for (int k = 0; k < 6; k++) tick();
        chk("stall_lost", err_lost_o, 1'b0);
        chk("stall_orphan", err_orphan_o, 1'b0);
        chk("stall_cnt_after", retire_cnt_o, 32'd5);

        // Nine retirements into a depth-8 FIFO with the consumer stalled.
        do_reset();
        stream(32'h0, 9, 13);
        chk("ovf_flag", err_overflow_o, 1'b1);
        chk("ovf_cnt", retire_cnt_o, 32'd8);
        chk("ovf_lost", err_lost_o, 1'b0);
        r = trace_rec_t'(exp_q[7]);
        chk("ovf_last_pc", r.slot.pc, 32'h1C);
        drain("ovf_drain", 12);

        // Full FIFO with a retire and a pop on the same edge.
        do_reset();
        stream(32'h400, 8, 12);
        chk("full_ovf0", err_overflow_o, 1'b0);
        chk("full_cnt8", retire_cnt_o, 32'd8);
        sx = mk_slot(32'h300);
        drive_idle(); set_iss(sx); tick();
        drive_idle();
        for (int k = 0; k < 3; k++) tick();
        trc_ready_i = 1'b1;
        retire_slot(sx, 32'h77, 32'h88, 32'h99);
        tick();
        trc_ready_i = 1'b0;
        drive_idle();
        chk("full_ovf_still0", err_overflow_o, 1'b0);
        chk("full_cnt9", retire_cnt_o, 32'd9);
        chk("full_q_depth", exp_q.size(), FD);
        drain("full_drain", 12);

        // Orphan retire, then an entry that leaves WB without retiring.
        do_reset();
        retire_i = 1'b1;
        tick();
        drive_idle();
        chk("orphan_flag", err_orphan_o, 1'b1);
        chk("orphan_nopush", trc_valid_o, 1'b0);
        chk("orphan_cnt", retire_cnt_o, '0);
        set_iss(mk_slot(32'h500));
        tick();
        drive_idle();
        for (int k = 0; k < 3; k++) tick();
        chk("lost_pre", err_lost_o, 1'b0);
        tick();
        chk("lost_flag", err_lost_o, 1'b1);
        chk("lost_nopush", trc_valid_o, 1'b0);
        chk("lost_ovf", err_overflow_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
